addr_load_serializer_4_8: RTL and testbench
===========================================

Name: addr_load_serializer_4_8

Overview:
- Writer-side counterpart of the 8-deep 4-bit tapped delay line.
- Nibbles are written by 3-bit address into an 8-slot bank. A start command then streams them out serially, slot 0 first, one nibble per CE-enabled cycle.
- The output stream is shaped to feed a shift-in chain: CE-gated, 4-bit, 8 nibbles per frame.
- It carries a 3-bit index so a downstream selector can correlate its taps.

Parameters:
- WIDTH, 4, nibble width in bits.
- DEPTH, 8, number of slots per frame. Must be a power of two.
- IDX_W, 3, log2(DEPTH). Width of the address and index fields.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- CE  input  1  clock enable for the output stream. Stalls shifting when low. Writes ignore CE.
- Din  input  WIDTH  write data.
- wr_en  input  1  write strobe.
- wr_addr  input  IDX_W  target slot for the write.
- start  input  1  request to serialize the current bank contents.
- Dout  output  WIDTH  serial nibble output, registered.
- dout_valid  output  1  high for exactly the cycles in which Dout carries a new nibble.
- count_8_out  output  IDX_W  slot index of the nibble currently on Dout.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse, coincident with the last nibble of a frame.

Behaviour:
- Reset (RST=1 at an edge):
  - All slots cleared to 0.
  - Dout=0, dout_valid=0, count_8_out=0, busy=0, done=0.
  - FSM goes to IDLE; internal index goes to 0.
  - Reset has priority over every other input. Reset mid-SHIFT aborts the frame with no done pulse.
- States: IDLE and SHIFT.
- IDLE:
  - wr_en=1 writes slot[wr_addr] <= Din at the edge.
  - start=1 moves the FSM to SHIFT at the edge and clears the index to 0.
  - If wr_en and start are high in the same cycle, the write lands first and is included in the frame.
  - dout_valid=0. Dout and count_8_out hold their last values.
- SHIFT:
  - Writes are ignored. The bank is frozen for the whole frame.
  - start is ignored.
  - CE=1 at an edge: Dout <= slot[idx], count_8_out <= idx, dout_valid <= 1, idx <= idx+1.
  - CE=0 at an edge: dout_valid <= 0. Dout, count_8_out and idx hold.
- Frame end:
  - The edge that emits idx=DEPTH-1 also sets done <= 1 and moves the FSM to IDLE.
  - busy drops on that same edge, so the final nibble (valid=1, done=1) is presented with busy=0.
  - done is high for exactly one cycle.
- Back-to-back frames: start may be asserted in the cycle where done=1. The FSM enters SHIFT at the next edge, giving a one-cycle bubble between frames.
- Latency: start high at edge T gives busy=1 after T. With CE held high, the first nibble appears after T+1 and the last after T+8. A frame takes 8 CE-enabled cycles.
- Contents persist: reading is non-destructive and slots keep their values after a frame. Restarting without new writes re-sends identical data.
- Index arithmetic is modulo DEPTH. Index wrap occurs only at frame end.
- No X propagation: unwritten slots read 0 after reset.

Decomposition:
- Shared package contains:
  - state enum {IDLE, SHIFT};
  - constants WIDTH=4, DEPTH=8, IDX_W=3.
- Sub-module slot_bank_4_8 holds the DEPTH x WIDTH register bank:
  - addressed write port;
  - combinational read by index;
  - synchronous active-high clear.
- The top level holds the FSM, the index counter and the registered output stage.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, then start. Expect 8 nibbles of 0x0 at count_8_out 0..7, then done.
- Load and stream: write slot k=k+1 for k=0..7, pulse start, CE=1. Expect Dout 1,2,...,8 with count_8_out 0..7 on consecutive cycles. done=1 with value 8; busy high for the 8 cycles before it.
- CE stall: same data as the load-and-stream case, with CE=0 during SHIFT cycles 3-4. Expect dout_valid=0 and Dout held at 3 during the stall, then 4..8 resume. Expect 10 cycles from start to done.
- Write during SHIFT: mid-frame, wr_en to slot 5 with 0xF. The current frame still outputs 6 at idx 5. A second start outputs the unchanged 1..8.
- Simultaneous events:
  - wr_en slot 0 = 0xA together with start: the frame's first nibble is 0xA.
  - start asserted on the done cycle: the next frame's first valid nibble follows after exactly one bubble cycle.
- Reset mid-frame: RST at idx 4. Expect all outputs 0 the next cycle, no done pulse, and a subsequent start streams 0x0 x8.

Source files
------------

// File: rtl/addr_load_serializer_4_8_pkg.sv
// Shared constants and FSM state type for the addressed-load nibble serializer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package addr_load_serializer_4_8_pkg;

    localparam int WIDTH = 4;  // nibble width
    localparam int DEPTH = 8;  // slots per frame, power of two
    localparam int IDX_W = 3;  // log2(DEPTH)

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/addr_load_serializer_4_8_slot_bank.sv
// DEPTH x WIDTH register bank: addressed write, combinational read by index, sync clear.
// Latency: write lands at the clock edge; read is combinational from rd_idx.
// Backpressure: none; the write enable is qualified by the caller.
// Ports: clk, clr (sync active-high), we/wr_addr/wr_dat write port, rd_idx/rd_dat read port.
module slot_bank_4_8
    import addr_load_serializer_4_8_pkg::*;
#(
    parameter int BANK_W = WIDTH,
    parameter int BANK_D = DEPTH,
    parameter int ADDR_W = IDX_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BANK_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [BANK_W-1:0] rd_dat
);

    logic [BANK_W-1:0] slots [BANK_D];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < BANK_D; i++) begin
                slots[i] <= '0;
            end
        end else if (we) begin
            slots[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = slots[rd_idx];

endmodule

// File: rtl/addr_load_serializer_4_8.sv
// Addressed nibble loader that streams an 8-slot bank out serially, slot 0 first, with index tag.
// Latency: start at edge T -> busy after T, first nibble after T+1, last (with done) after T+8 at CE=1.
// Backpressure: CE low stalls the stream (dout_valid drops, Dout/index hold); writes ignore CE.
// Ports: CLK, RST (sync active-high); CE; write port Din/wr_en/wr_addr; start;
//        outputs Dout, dout_valid, count_8_out (slot of Dout), busy (in SHIFT), done (last nibble).
module addr_load_serializer_4_8
    import addr_load_serializer_4_8_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [WIDTH-1:0] Din,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic             start,
    output logic [WIDTH-1:0] Dout,
    output logic             dout_valid,
    output logic [IDX_W-1:0] count_8_out,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] rd_dat;
    logic             bank_we;

    // Bank is frozen while a frame is in flight. A write coinciding with start
    // is taken in IDLE, so it is already in the bank when slot 0 is read.
    assign bank_we = wr_en && (state == IDLE);

    slot_bank_4_8 u_bank (
        .clk     (CLK),
        .clr     (RST),
        .we      (bank_we),
        .wr_addr (wr_addr),
        .wr_dat  (Din),
        .rd_idx  (idx),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Leave on the edge that emits the last slot, so busy is already
                // low while the final nibble is presented.
                if (CE && (idx == LAST_IDX)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx         <= '0;
            Dout        <= '0;
            dout_valid  <= 1'b0;
            count_8_out <= '0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dout_valid <= 1'b0;
                    done       <= 1'b0;
                    if (start) begin
                        idx <= '0;
                    end
                end
                SHIFT: begin
                    if (CE) begin
                        Dout        <= rd_dat;
                        count_8_out <= idx;
                        dout_valid  <= 1'b1;
                        done        <= (idx == LAST_IDX);
                        idx         <= idx + 1'b1;  // wraps to 0 exactly at frame end
                    end else begin
                        dout_valid  <= 1'b0;
                        done        <= 1'b0;
                    end
                end
                default: begin
                    dout_valid <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_addr_load_serializer_4_8.sv
module tb_addr_load_serializer_4_8;
    import addr_load_serializer_4_8_pkg::*;

    logic             CLK = 1'b0;
    logic             RST;
    logic             CE;
    logic [WIDTH-1:0] Din;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic             start;
    logic [WIDTH-1:0] Dout;
    logic             dout_valid;
    logic [IDX_W-1:0] count_8_out;
    logic             busy;
    logic             done;

    addr_load_serializer_4_8 dut (
        .CLK         (CLK),
        .RST         (RST),
        .CE          (CE),
        .Din         (Din),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .start       (start),
        .Dout        (Dout),
        .dout_valid  (dout_valid),
        .count_8_out (count_8_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [IDX_W-1:0] i;
        logic             dn;
        logic             bz;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    exp_t             mon_a;
    logic [WIDTH-1:0] exp_mem [DEPTH];
    int               checks = 0;
    int               errors = 0;
    int               n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every presented nibble must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (done && !dout_valid) begin
            checks++;
            errors++;
            $display("FAIL done_without_valid actual=1 required=0");
        end
        if (dout_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_nibble actual=%0h@%0d required=none", Dout, count_8_out);
            end else begin
                mon_e = sb.pop_front();
                mon_a = '{d: Dout, i: count_8_out, dn: done, bz: busy};
                chk("nibble{d,idx,done,busy}", 32'(mon_a), 32'(mon_e));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_frame();
        exp_t e;
        for (int k = 0; k < DEPTH; k++) begin
            e.d  = exp_mem[k];
            e.i  = IDX_W'(k);
            e.dn = (k == DEPTH - 1);
            e.bz = (k != DEPTH - 1);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            cyc++;
            if (done) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout actual=%0d required=done", cyc);
    endtask

    task automatic write_slot(input logic [IDX_W-1:0] a, input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        Din     = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_dout"},  32'(Dout), 0);
        chk({tag, "_valid"}, 32'(dout_valid), 0);
        chk({tag, "_count"}, 32'(count_8_out), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; CE = 1'b1; Din = '0; wr_en = 1'b0; wr_addr = '0; start = 1'b0;

        // Reset then idle: unwritten slots stream as zeros
        tick(); tick();
        RST = 1'b0;
        chk_zero_outputs("reset");
        for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;
        push_frame();
        pulse_start();
        chk("busy_after_start", 32'(busy), 1);
        wait_done(n);
        chk("zero_frame_cycles", n, 8);

        // Load and stream 1..8
        for (int k = 0; k < DEPTH; k++) begin
            exp_mem[k] = WIDTH'(k + 1);
            write_slot(IDX_W'(k), WIDTH'(k + 1));
        end
        push_frame();
        pulse_start();
        wait_done(n);
        chk("load_frame_cycles", n, 8);

        // CE stall after third nibble
        push_frame();
        pulse_start();
        repeat (3) tick();
        CE = 1'b0;
        tick();
        chk("stall1_valid", 32'(dout_valid), 0);
        chk("stall1_dout", 32'(Dout), 3);
        tick();
        chk("stall2_valid", 32'(dout_valid), 0);
        chk("stall2_dout", 32'(Dout), 3);
        chk("stall2_count", 32'(count_8_out), 2);
        CE = 1'b1;
        wait_done(n);
        chk("stall_frame_cycles", n + 5, 10);

        // Write during SHIFT is ignored, now and for the next frame
        push_frame();
        pulse_start();
        tick(); tick();
        write_slot(3'd5, 4'hF);
        wait_done(n);
        push_frame();
        pulse_start();
        wait_done(n);

        // Write coincident with start lands in the frame
        exp_mem[0] = 4'hA;
        push_frame();
        wr_en = 1'b1; wr_addr = '0; Din = 4'hA; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        wait_done(n);

        // Start on the done cycle: one bubble, then the next frame
        push_frame();
        pulse_start();
        wait_done(n);
        push_frame();
        pulse_start();
        chk("bubble_valid", 32'(dout_valid), 0);
        chk("bubble_busy", 32'(busy), 1);
        tick();
        chk("after_bubble_valid", 32'(dout_valid), 1);
        wait_done(n);
        chk("b2b_remaining_cycles", n, 7);

        // Reset mid-frame at idx 4
        push_frame();
        pulse_start();
        n = 0;
        while (!(dout_valid && count_8_out == 3'd4) && n < 20) begin
            tick();
            n++;
        end
        chk("reached_idx4", 32'(dout_valid && count_8_out == 3'd4), 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        sb.delete();
        chk_zero_outputs("midreset");
        repeat (3) tick();
        chk("no_done_after_reset", 32'(done), 0);
        for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;
        push_frame();
        pulse_start();
        wait_done(n);
        chk("post_reset_frame_cycles", n, 8);
        tick();

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
